// File: rtl/hub75_pkg.sv
// ---------------------------------------------------------------------------
// hub75_pkg
//   Shared constants and types for the HUB75 scan driver: panel geometry,
//   address/counter widths, the scan FSM state encoding and the pixel bundle.
// ---------------------------------------------------------------------------
package hub75_pkg;

   localparam int unsigned COLUMNS = 64;
   localparam int unsigned LINES   = 32;

   localparam int unsigned COL_W   = $clog2(COLUMNS);
   localparam int unsigned LINE_W  = $clog2(LINES);
   localparam int unsigned CNT_W   = 16;

   localparam logic [COL_W-1:0] LAST_COLUMN = COL_W'(COLUMNS - 1);

   typedef enum logic [1:0] {
      ST_SHIFT = 2'd0,
      ST_WAIT  = 2'd1,
      ST_BLANK = 2'd2,
      ST_LATCH = 2'd3
   } hub75_state_t;

   // One column's worth of serial data: upper half (1) and lower half (2).
   typedef struct packed {
      logic r1;
      logic g1;
      logic b1;
      logic r2;
      logic g2;
      logic b2;
   } hub75_pix_t;

endpackage

// File: rtl/hub75_oe_timer.sv
// ---------------------------------------------------------------------------
// hub75_oe_timer
//   Display-time counter and registered output-enable for the panel.
//   The counter is cleared and the panel enabled by start_i (the LATCH
//   cycle); it then counts every enabled cycle and disables the panel after
//   exactly DISPLAY_CYCLES cycles. Output enable stays high out of reset
//   until the first start_i.
//
//   Ports
//     clk      in   clock
//     rst_n    in   asynchronous active-low reset
//     start_i  in   restart the display window (held for one cycle)
//     oe_n_o   out  registered panel output enable, active-low
//     done_o   out  display window ends at the end of the current cycle or
//                   has already ended
// ---------------------------------------------------------------------------
module hub75_oe_timer
   import hub75_pkg::*;
#(
   parameter int unsigned DISPLAY_CYCLES = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start_i,
   output logic oe_n_o,
   output logic done_o
);

   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DISPLAY_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             oe_n_q, oe_n_d;

   always_comb begin
      cnt_d  = cnt_q;
      oe_n_d = oe_n_q;
      if (start_i) begin
         cnt_d  = '0;
         oe_n_d = 1'b0;
      end else if (!oe_n_q) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == LAST_COUNT) begin
            oe_n_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         oe_n_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         oe_n_q <= oe_n_d;
      end
   end

   assign oe_n_o = oe_n_q;
   // The counter freezes at DISPLAY_CYCLES, so ">=" covers both the final
   // enabled cycle and every cycle after it.
   assign done_o = (cnt_q >= LAST_COUNT);

endmodule

// File: rtl/hub75_scan_driver.sv
// ---------------------------------------------------------------------------
// hub75_scan_driver
//   Scans a 64x32 HUB75 panel (two half-panels, 1 bit per colour). For each
//   line the pattern source is addressed column by column, the six pixel
//   bits are shifted out with two clk cycles per column, the line is latched
//   and its row address applied, and the next line is shifted while the
//   latched one is displayed for DISPLAY_CYCLES cycles.
//
//   Ports
//     clk                      in   clock
//     rst_n                    in   asynchronous active-low reset
//     line[4:0]                out  line address to the pattern source
//     column[5:0]              out  column address to the pattern source
//     r1,g1,b1,r2,g2,b2        in   pixel bits for (line, column)
//     hub_clk                  out  panel shift clock
//     hub_lat                  out  panel latch
//     hub_oe_n                 out  panel output enable, active-low
//     hub_addr[4:0]            out  panel row select A..E
//     hub_r1..hub_b2           out  panel serial data
//   All outputs are registered.
// ---------------------------------------------------------------------------
module hub75_scan_driver
   import hub75_pkg::*;
#(
   parameter int unsigned DISPLAY_CYCLES = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [LINE_W-1:0] line,
   output logic [COL_W-1:0]  column,
   input  logic              r1,
   input  logic              g1,
   input  logic              b1,
   input  logic              r2,
   input  logic              g2,
   input  logic              b2,
   output logic              hub_clk,
   output logic              hub_lat,
   output logic              hub_oe_n,
   output logic [LINE_W-1:0] hub_addr,
   output logic              hub_r1,
   output logic              hub_g1,
   output logic              hub_b1,
   output logic              hub_r2,
   output logic              hub_g2,
   output logic              hub_b2
);

   hub75_state_t      state_q, state_d;
   logic              phase_q, phase_d;
   logic [COL_W-1:0]  column_q, column_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic              displayed_q, displayed_d;
   logic              hub_clk_q, hub_clk_d;
   logic              hub_lat_q, hub_lat_d;
   logic [LINE_W-1:0] hub_addr_q, hub_addr_d;
   hub75_pix_t        pix_q, pix_d;

   hub75_pix_t        pix_in;
   logic              oe_done;
   logic              show_done;

   assign pix_in = '{r1: r1, g1: g1, b1: b1, r2: r2, g2: g2, b2: b2};

   // Before the first latch nothing is on the panel, so there is nothing to
   // wait for.
   assign show_done = !displayed_q || oe_done;

   hub75_oe_timer #(
      .DISPLAY_CYCLES (DISPLAY_CYCLES)
   ) u_oe_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (state_q == ST_LATCH),
      .oe_n_o  (hub_oe_n),
      .done_o  (oe_done)
   );

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      column_d    = column_q;
      line_d      = line_q;
      displayed_d = displayed_q;
      pix_d       = pix_q;
      hub_addr_d  = hub_addr_q;

      case (state_q)
         ST_SHIFT: begin
            phase_d = ~phase_q;
            if (!phase_q) begin
               pix_d = pix_in;
            end else begin
               column_d = column_q + COL_W'(1);
               // WAIT is passed through in zero cycles when the display
               // window is already over, giving a max(128, DISPLAY_CYCLES)+2
               // line period.
               if (column_q == LAST_COLUMN) begin
                  state_d = show_done ? ST_BLANK : ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (show_done) begin
               state_d = ST_BLANK;
            end
         end
         ST_BLANK: begin
            state_d = ST_LATCH;
         end
         ST_LATCH: begin
            state_d     = ST_SHIFT;
            line_d      = line_q + LINE_W'(1);
            displayed_d = 1'b1;
         end
         default: begin
            state_d = ST_SHIFT;
         end
      endcase

      // Strobe outputs are decoded from the next state so that they are
      // registered yet coincide with the state they belong to.
      hub_clk_d = (state_d == ST_SHIFT) && phase_d;
      hub_lat_d = (state_d == ST_LATCH);
      if (state_d == ST_LATCH) begin
         hub_addr_d = line_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_SHIFT;
         phase_q     <= 1'b0;
         column_q    <= '0;
         line_q      <= '0;
         displayed_q <= 1'b0;
         hub_clk_q   <= 1'b0;
         hub_lat_q   <= 1'b0;
         hub_addr_q  <= '0;
         pix_q       <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         column_q    <= column_d;
         line_q      <= line_d;
         displayed_q <= displayed_d;
         hub_clk_q   <= hub_clk_d;
         hub_lat_q   <= hub_lat_d;
         hub_addr_q  <= hub_addr_d;
         pix_q       <= pix_d;
      end
   end

   assign line     = line_q;
   assign column   = column_q;
   assign hub_clk  = hub_clk_q;
   assign hub_lat  = hub_lat_q;
   assign hub_addr = hub_addr_q;
   assign hub_r1   = pix_q.r1;
   assign hub_g1   = pix_q.g1;
   assign hub_b1   = pix_q.b1;
   assign hub_r2   = pix_q.r2;
   assign hub_g2   = pix_q.g2;
   assign hub_b2   = pix_q.b2;

endmodule

// File: tb/tb_hub75_scan_driver.sv
module tb_hub75_scan_driver;

   localparam int unsigned DC_A = 256;
   localparam int unsigned DC_B = 40;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a_n, rst_b_n;

   logic [4:0] line_a, line_b, haddr_a, haddr_b;
   logic [5:0] column_a, column_b, pin_a, pin_b;
   logic hclk_a, hlat_a, hoe_a, hr1_a, hg1_a, hb1_a, hr2_a, hg2_a, hb2_a;
   logic hclk_b, hlat_b, hoe_b, hr1_b, hg1_b, hb1_b, hr2_b, hg2_b, hb2_b;

   // Pattern source: {r1,g1,b1,r2,g2,b2} as a function of line/column.
   function automatic logic [5:0] pattern(input logic [4:0] l, input logic [5:0] c);
      return {c[0], c[1], l[1], c[5], l[4] ^ c[0], l[0]};
   endfunction

   assign pin_a = pattern(line_a, column_a);
   assign pin_b = pattern(line_b, column_b);

   hub75_scan_driver #(.DISPLAY_CYCLES(DC_A)) dut_a (
      .clk(clk), .rst_n(rst_a_n), .line(line_a), .column(column_a),
      .r1(pin_a[5]), .g1(pin_a[4]), .b1(pin_a[3]), .r2(pin_a[2]), .g2(pin_a[1]), .b2(pin_a[0]),
      .hub_clk(hclk_a), .hub_lat(hlat_a), .hub_oe_n(hoe_a), .hub_addr(haddr_a),
      .hub_r1(hr1_a), .hub_g1(hg1_a), .hub_b1(hb1_a), .hub_r2(hr2_a), .hub_g2(hg2_a), .hub_b2(hb2_a)
   );

   hub75_scan_driver #(.DISPLAY_CYCLES(DC_B)) dut_b (
      .clk(clk), .rst_n(rst_b_n), .line(line_b), .column(column_b),
      .r1(pin_b[5]), .g1(pin_b[4]), .b1(pin_b[3]), .r2(pin_b[2]), .g2(pin_b[1]), .b2(pin_b[0]),
      .hub_clk(hclk_b), .hub_lat(hlat_b), .hub_oe_n(hoe_b), .hub_addr(haddr_b),
      .hub_r1(hr1_b), .hub_g1(hg1_b), .hub_b1(hb1_b), .hub_r2(hr2_b), .hub_g2(hg2_b), .hub_b2(hb2_b)
   );

   typedef struct packed {
      logic       clk_o;
      logic       lat;
      logic       oe_n;
      logic [4:0] addr;
      logic [4:0] line;
      logic [5:0] col;
      logic [5:0] pix;
   } mon_t;

   mon_t s_a, s_b;
   assign s_a = {hclk_a, hlat_a, hoe_a, haddr_a, line_a, column_a,
                 hr1_a, hg1_a, hb1_a, hr2_a, hg2_a, hb2_a};
   assign s_b = {hclk_b, hlat_b, hoe_b, haddr_b, line_b, column_b,
                 hr1_b, hg1_b, hb1_b, hr2_b, hg2_b, hb2_b};

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Scoreboard: expected serial pixels per DUT, one line pushed when that
   // line's shift begins, popped on every hub_clk rising edge.
   logic [5:0] q_a[$];
   logic [5:0] q_b[$];

   int unsigned cyc [2];
   int unsigned oe_cnt [2];
   int unsigned rises [2];
   int unsigned lat_cnt [2];
   logic [5:0]  exp_col [2];
   logic [4:0]  exp_line [2];
   logic [4:0]  prev_addr [2];
   logic        prev_clk [2];
   logic        first [2];
   logic        after_lat [2];

   function automatic int unsigned period_of(input int unsigned dc);
      return ((dc > 128) ? dc : 128) + 2;
   endfunction

   task automatic push_line(input int idx, input logic [4:0] l);
      for (int unsigned c = 0; c < 64; c++) begin
         if (idx == 0) q_a.push_back(pattern(l, 6'(c)));
         else          q_b.push_back(pattern(l, 6'(c)));
      end
   endtask

   task automatic mon_reinit(input int idx);
      if (idx == 0) q_a.delete(); else q_b.delete();
      cyc[idx] = 1; oe_cnt[idx] = 0; rises[idx] = 0;
      exp_col[idx] = '0; exp_line[idx] = '0; prev_addr[idx] = '0;
      prev_clk[idx] = 1'b0; first[idx] = 1'b1; after_lat[idx] = 1'b0;
      push_line(idx, 5'd0);
   endtask

   task automatic mon_step(input int idx, input mon_t s);
      string p;
      logic [5:0] v;
      int unsigned qsz;
      p = (idx == 0) ? "A " : "B ";
      cyc[idx]++;
      if (s.clk_o || s.lat) check_eq({p, "lat_clk_exclusive"}, 32'(s.clk_o & s.lat), 0);
      if (after_lat[idx]) begin
         check_eq({p, "lat_one_cycle"}, 32'(s.lat), 0);
         check_eq({p, "oe_low_after_latch"}, 32'(s.oe_n), 0);
         after_lat[idx] = 1'b0;
      end
      if (!s.oe_n) oe_cnt[idx]++;
      if (s.addr != prev_addr[idx]) check_eq({p, "addr_change_in_latch"}, 32'(s.lat), 1);
      prev_addr[idx] = s.addr;
      if (s.clk_o && !prev_clk[idx]) begin
         rises[idx]++;
         check_eq({p, "column_order"}, 32'(s.col), 32'(exp_col[idx]));
         check_eq({p, "line_out"}, 32'(s.line), 32'(exp_line[idx]));
         qsz = (idx == 0) ? q_a.size() : q_b.size();
         if (qsz == 0) begin
            check_eq({p, "sb_underflow"}, 1, 0);
         end else begin
            v = (idx == 0) ? q_a.pop_front() : q_b.pop_front();
            check_eq({p, "serial_pixel"}, 32'(s.pix), 32'(v));
         end
         exp_col[idx] = exp_col[idx] + 6'd1;
      end
      prev_clk[idx] = s.clk_o;
      if (s.lat) begin
         qsz = (idx == 0) ? q_a.size() : q_b.size();
         check_eq({p, "lat_oe_high"}, 32'(s.oe_n), 1);
         check_eq({p, "lat_addr"}, 32'(s.addr), 32'(exp_line[idx]));
         check_eq({p, "clk_rises_per_line"}, rises[idx], 64);
         check_eq({p, "sb_left_at_latch"}, qsz, 0);
         check_eq({p, "line_period"}, cyc[idx],
                  first[idx] ? 130 : period_of(idx == 0 ? DC_A : DC_B));
         check_eq({p, "oe_low_cycles"}, oe_cnt[idx],
                  first[idx] ? 0 : (idx == 0 ? DC_A : DC_B));
         first[idx] = 1'b0; cyc[idx] = 0; oe_cnt[idx] = 0; rises[idx] = 0;
         exp_col[idx] = '0; after_lat[idx] = 1'b1; lat_cnt[idx]++;
         exp_line[idx] = exp_line[idx] + 5'd1;
         push_line(idx, exp_line[idx]);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_a_n) mon_reinit(0); else mon_step(0, s_a);
      if (!rst_b_n) mon_reinit(1); else mon_step(1, s_b);
   end

   task automatic check_reset(input string p, input mon_t s);
      check_eq({p, "rst_hub_clk"}, 32'(s.clk_o), 0);
      check_eq({p, "rst_hub_lat"}, 32'(s.lat), 0);
      check_eq({p, "rst_hub_oe_n"}, 32'(s.oe_n), 1);
      check_eq({p, "rst_hub_addr"}, 32'(s.addr), 0);
      check_eq({p, "rst_line"}, 32'(s.line), 0);
      check_eq({p, "rst_column"}, 32'(s.col), 0);
      check_eq({p, "rst_data"}, 32'(s.pix), 0);
   endtask

   task automatic wait_lat_a(input int unsigned target, input int unsigned budget);
      int unsigned n;
      n = 0;
      while (lat_cnt[0] < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_eq("A wait_latch_count", 32'(lat_cnt[0] >= target), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, latches A %0d B %0d", lat_cnt[0], lat_cnt[1]);
      $fatal(1);
   end

   initial begin
      bit hit;
      lat_cnt[0] = 0;
      lat_cnt[1] = 0;
      rst_a_n = 1'b0;
      rst_b_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("A ", s_a);
      check_reset("B ", s_b);
      #1;
      rst_a_n = 1'b1;
      rst_b_n = 1'b1;

      // 39 latched lines: addr 0..31,0..6, then shifting line 7.
      wait_lat_a(39, 12000);

      hit = 1'b0;
      for (int unsigned i = 0; i < 300 && !hit; i++) begin
         @(posedge clk);
         #2;
         if (column_a == 6'd20) hit = 1'b1;
      end
      check_eq("A reached_column_20", 32'(hit), 1);
      check_eq("A line_before_reset", 32'(line_a), 7);
      check_eq("A oe_before_reset", 32'(hoe_a), 0);
      rst_a_n = 1'b0;
      #1;
      check_reset("A mid ", s_a);

      repeat (2) @(negedge clk);
      #1;
      rst_a_n = 1'b1;
      wait_lat_a(41, 700);

      check_eq("B latch_count", 32'(lat_cnt[1] >= 70), 1);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
